seq_gen: RTL

SEQ_GEN -- requirements
Module: seq_gen

---
 rtl/seq_gen_if.sv | 24 ++
 rtl/seq_gen.sv | 123 ++++++++++++
 2 files changed

// File: rtl/seq_gen_if.sv
// Control/data bundle for seq_gen: transmit request fields in, serial stream and status out.
interface seq_gen_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] data;
  logic [4:0]   len;
  logic [3:0]   reps;
  logic         abort;
  logic         out;
  logic         out_valid;
  logic         busy;
  logic         done;

  modport master (
    output start, data, len, reps, abort,
    input  out, out_valid, busy, done
  );

  modport slave (
    input  start, data, len, reps, abort,
    output out, out_valid, busy, done
  );
endinterface

// File: rtl/seq_gen.sv
// Serial pattern generator: sends the low L bits of a captured word MSB-first,
// repeated reps extra times with a one-cycle gap between frames.
module seq_gen #(
  parameter int W = 8
) (
  input logic     clk,
  input logic     reset,
  seq_gen_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t       state_reg, state_next;
  logic [W-1:0] data_reg, data_next;
  logic [4:0]   len_reg, len_next;
  logic [4:0]   idx_reg, idx_next;
  logic [3:0]   reps_reg, reps_next;
  logic         out_reg, out_next;
  logic         out_valid_reg, out_valid_next;
  logic         busy_reg, busy_next;
  logic         done_reg, done_next;

  logic [4:0]   len_eff;
  logic [W-1:0] sel_data;
  logic [4:0]   sel_idx;
  logic [W-1:0] sel_shifted;

  // Out-of-range lengths (0 or wider than the data word) fall back to full width.
  assign len_eff = (bus.len == 5'd0 || bus.len > 5'(W)) ? 5'(W) : bus.len;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      data_reg      <= '0;
      len_reg       <= '0;
      idx_reg       <= '0;
      reps_reg      <= '0;
      out_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      data_reg      <= data_next;
      len_reg       <= len_next;
      idx_reg       <= idx_next;
      reps_reg      <= reps_next;
      out_reg       <= out_next;
      out_valid_reg <= out_valid_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    data_next      = data_reg;
    len_next       = len_reg;
    idx_next       = idx_reg;
    reps_next      = reps_reg;
    out_valid_next = 1'b0;
    busy_next      = 1'b0;
    done_next      = 1'b0;
    sel_data       = data_reg;
    sel_idx        = idx_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_next     = SHIFT;
          data_next      = bus.data;
          len_next       = len_eff;
          reps_next      = bus.reps;
          idx_next       = len_eff - 5'd1;
          sel_data       = bus.data;
          sel_idx        = len_eff - 5'd1;
          out_valid_next = 1'b1;
          busy_next      = 1'b1;
        end
      end
      SHIFT: begin
        if (idx_reg == 5'd0) begin
          if (reps_reg != 4'd0) begin
            state_next = GAP;
            reps_next  = reps_reg - 4'd1;
            busy_next  = 1'b1;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end else begin
          idx_next       = idx_reg - 5'd1;
          sel_idx        = idx_reg - 5'd1;
          out_valid_next = 1'b1;
          busy_next      = 1'b1;
        end
      end
      GAP: begin
        state_next     = SHIFT;
        idx_next       = len_reg - 5'd1;
        sel_idx        = len_reg - 5'd1;
        out_valid_next = 1'b1;
        busy_next      = 1'b1;
      end
      default: state_next = IDLE;
    endcase

    // Abort only cancels an active transmission; in IDLE it merely masks start.
    if (bus.abort && state_reg != IDLE) begin
      state_next     = IDLE;
      out_valid_next = 1'b0;
      busy_next      = 1'b0;
      done_next      = 1'b0;
    end

    sel_shifted = sel_data >> sel_idx;
    out_next    = out_valid_next & sel_shifted[0];
  end

  assign bus.out       = out_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
endmodule
